cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, two-stage pipelined carry-lookahead adder/subtractor for the datapath ALU. It builds a WIDTH-bit adder from 4-bit lookahead groups and a block-level lookahead across groups, with a register boundary between them. The valid/ready handshake lets the ALU stream one operation per cycle or stall on backpressure. It also produces carry, signed-overflow, zero and negative flags for the condition logic.

## Interface
- WIDTH, 32, operand width; multiple of 4, legal range 4..64; group count NG = WIDTH/4
- clk  in  1  rising-edge clock
- clr  in  1  synchronous, active-high reset
- in_valid  in  1  operand set presented
- in_ready  out  1  block accepts operands this cycle; transfer when in_valid & in_ready
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_carry  in  1  carry-in (add) / borrow-in (sub)
- in_sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result; transfer when out_valid & out_ready
- out_sum  out  WIDTH  result
- out_carry  out  1  carry out of MSB (sub: 1 = no borrow)
- out_overflow  out  1  two's-complement overflow
- out_zero  out  1  out_sum == 0
- out_negative  out  1  out_sum[WIDTH-1]

## Operation
- Effective operand: b_eff = in_sub ? ~in_b : in_b; cin_eff = in_sub ? ~in_carry : in_carry.
- add: sum = A + B + in_carry. sub: sum = A − B − in_carry.
- All results are computed modulo 2^WIDTH; carry is bit WIDTH of the unsigned sum A + b_eff + cin_eff.
- Stage 1 (on input transfer), registered:
  - per-bit p = a ^ b_eff, g = a & b_eff
  - per-group P = &p[4k+3:4k]
  - per-group G = g3 | g2·p3 | g1·p3·p2 | g0·p3·p2·p1
  - cin_eff, a[MSB], b_eff[MSB], s1_valid
- Stage 2 (on stage-1 advance), registered:
  - group carry-ins c[0] = cin_eff, c[k+1] = G[k] | P[k]·c[k]; computed as a flat lookahead, no ripple chain across groups
  - bit carries inside each group use the 4-bit lookahead equations seeded by c[k]
  - sum = p ^ carry_in_vector; out_carry = c[NG]
  - out_overflow = (a_msb == b_eff_msb) & (sum_msb != a_msb)
- Handshake:
  - out_adv = ~out_valid | out_ready
  - s1_adv = ~s1_valid | out_adv
  - in_ready = s1_adv & ~clr (combinational)
- Pipeline contract:
  - no result is ever dropped or duplicated; order is preserved
  - out_* are held stable while out_valid & ~out_ready
- Reset (clr high at a clock edge):
  - s1_valid, out_valid, out_sum and all flags go to 0; stage-1 data regs go to 0
  - in-flight operations are discarded
  - in_ready is 0 during the clr cycle and 1 on the first cycle after
- Simultaneous clr and input transfer: clr wins and nothing is captured (in_ready is already 0).

## Timing
- Latency: 2 cycles. An operand accepted at edge N produces out_valid high after edge N+1, with the result on outputs from that point.
- Throughput: 1 op/cycle while out_ready is held high.
- Capacity: 2 ops (stage 1 + output).
  - With out_ready low, the second accepted op parks in stage 1.
  - in_ready then falls in the same cycle (combinational from out_ready and valid bits).
- When out_ready rises, in_ready rises in the same cycle, so drain and accept happen on one edge.
- Critical path per stage is at most one 4-bit lookahead plus an NG-wide lookahead. No path spans both stages.

## Test plan
- WIDTH=32, add 0x00000005 + 0x00000003, cin=0 -> two cycles later sum=0x00000008, carry=0, ovf=0, zero=0, neg=0.
- Add 0xFFFFFFFF + 0x00000001, cin=0 (carry through every group) -> sum=0x00000000, carry=1, zero=1, ovf=0. Repeat with WIDTH=4 and WIDTH=64 and check the same flags.
- Sub 0x7FFFFFFF − 0xFFFFFFFF, borrow=0 -> sum=0x80000000, ovf=1, neg=1, carry=0. Then sub 0x00000005 − 0x00000005 -> sum=0, carry=1, zero=1.
- Stream A=1..4 (B=1, add) on consecutive cycles. Drop out_ready for 2 cycles after the first result:
  - in_ready falls once 2 ops are held
  - outputs stay frozen at 2 while stalled
  - results 2,3,4,5 arrive in order, with no loss or duplicate
- Assert clr for one cycle with 2 ops in flight -> next cycle out_valid=0, all outputs 0, in_ready=1. The next accepted op (7+8) yields 15 after 2 cycles.
- Random 10k ops (mixed add/sub, random cin and out_ready) vs a behavioural A ± B ± c model -> all sum and flag values match.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with flags.
// Stage 1 forms group P/G, stage 2 resolves carries and the sum.
module cla_pipe_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_negative
);

  localparam int NG = WIDTH / 4;

  logic             out_adv;
  logic             s1_adv;
  logic             in_fire;

  logic [WIDTH-1:0] b_eff;
  logic             cin_in;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic [NG-1:0]    gp_in;
  logic [NG-1:0]    gg_in;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [NG-1:0][2:0] s1_g;
  logic [NG-1:0]    s1_gp;
  logic [NG-1:0]    s1_gg;
  logic             s1_cin;
  logic             s1_a_msb;
  logic             s1_b_msb;

  logic [NG:0]      gc;
  logic             acc;
  logic             prod;
  logic [WIDTH-1:0] cv;
  logic [3:0]       pk;
  logic [2:0]       gk;
  logic             ck;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  assign out_adv  = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | out_adv;
  assign in_ready = s1_adv & ~clr;
  assign in_fire  = in_valid & in_ready;

  // Effective operands and per-group propagate/generate.
  always_comb begin
    b_eff  = in_sub ? ~in_b : in_b;
    cin_in = in_sub ? ~in_carry : in_carry;
    p_in   = in_a ^ b_eff;
    g_in   = in_a & b_eff;
    gp_in  = '0;
    gg_in  = '0;
    for (int k = 0; k < NG; k++) begin
      gp_in[k] = &p_in[4*k +: 4];
      gg_in[k] = g_in[4*k+3]
               | (g_in[4*k+2] & p_in[4*k+3])
               | (g_in[4*k+1] & p_in[4*k+3]
                  & p_in[4*k+2])
               | (g_in[4*k]   & p_in[4*k+3]
                  & p_in[4*k+2] & p_in[4*k+1]);
    end
  end

  // Stage-1 register: captures P/G terms on an input transfer.
  always_ff @(posedge clk) begin
    if (clr) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_gp    <= '0;
      s1_gg    <= '0;
      s1_cin   <= 1'b0;
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_p     <= p_in;
        for (int k = 0; k < NG; k++)
          s1_g[k] <= g_in[4*k +: 3];
        s1_gp    <= gp_in;
        s1_gg    <= gg_in;
        s1_cin   <= cin_in;
        s1_a_msb <= in_a[WIDTH-1];
        s1_b_msb <= b_eff[WIDTH-1];
      end
    end
  end

  // Flat block lookahead: each group carry is a sum of
  // products of G/P terms, never a chain through c[k].
  always_comb begin
    gc    = '0;
    acc   = 1'b0;
    prod  = 1'b0;
    gc[0] = s1_cin;
    for (int k = 0; k < NG; k++) begin
      acc  = s1_gg[k];
      prod = s1_gp[k];
      for (int j = k - 1; j >= 0; j--) begin
        acc  = acc | (prod & s1_gg[j]);
        prod = prod & s1_gp[j];
      end
      gc[k+1] = acc | (prod & s1_cin);
    end
  end

  // Bit carries inside each group, seeded by its group carry.
  always_comb begin
    cv = '0;
    pk = '0;
    gk = '0;
    ck = 1'b0;
    for (int k = 0; k < NG; k++) begin
      pk = s1_p[4*k +: 4];
      gk = s1_g[k];
      ck = gc[k];
      cv[4*k]   = ck;
      cv[4*k+1] = gk[0] | (pk[0] & ck);
      cv[4*k+2] = gk[1]
                | (pk[1] & gk[0])
                | (pk[1] & pk[0] & ck);
      cv[4*k+3] = gk[2]
                | (pk[2] & gk[1])
                | (pk[2] & pk[1] & gk[0])
                | (pk[2] & pk[1] & pk[0] & ck);
    end
    sum = s1_p ^ cv;
    ovf = (s1_a_msb == s1_b_msb)
        & (sum[WIDTH-1] != s1_a_msb);
  end

  // Output register: loads on advance, holds under stall.
  always_ff @(posedge clk) begin
    if (clr) begin
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
      out_negative <= 1'b0;
    end else if (out_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum      <= sum;
        out_carry    <= gc[NG];
        out_overflow <= ovf;
        out_zero     <= ~|sum;
        out_negative <= sum[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed scenarios plus a
// randomized stream against an arithmetic reference model.
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic        in_carry, in_sub;
  logic        out_valid, out_ready;
  logic [31:0] out_sum;
  logic        out_carry, out_overflow, out_zero, out_negative;

  logic        w4_in_valid, w4_in_ready;
  logic [3:0]  w4_in_a, w4_in_b, w4_out_sum;
  logic        w4_out_valid, w4_out_carry, w4_out_overflow;
  logic        w4_out_zero, w4_out_negative;

  logic        w64_in_valid, w64_in_ready;
  logic [63:0] w64_in_a, w64_in_b, w64_out_sum;
  logic        w64_out_valid, w64_out_carry, w64_out_overflow;
  logic        w64_out_zero, w64_out_negative;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_carry(in_carry), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry),
    .out_overflow(out_overflow), .out_zero(out_zero),
    .out_negative(out_negative)
  );

  cla_pipe_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .clr(clr),
    .in_valid(w4_in_valid), .in_ready(w4_in_ready),
    .in_a(w4_in_a), .in_b(w4_in_b),
    .in_carry(1'b0), .in_sub(1'b0),
    .out_valid(w4_out_valid), .out_ready(1'b1),
    .out_sum(w4_out_sum), .out_carry(w4_out_carry),
    .out_overflow(w4_out_overflow), .out_zero(w4_out_zero),
    .out_negative(w4_out_negative)
  );

  cla_pipe_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .clr(clr),
    .in_valid(w64_in_valid), .in_ready(w64_in_ready),
    .in_a(w64_in_a), .in_b(w64_in_b),
    .in_carry(1'b0), .in_sub(1'b0),
    .out_valid(w64_out_valid), .out_ready(1'b1),
    .out_sum(w64_out_sum), .out_carry(w64_out_carry),
    .out_overflow(w64_out_overflow), .out_zero(w64_out_zero),
    .out_negative(w64_out_negative)
  );

  function automatic res_t model(
    logic [31:0] a, logic [31:0] b, logic c, logic s);
    res_t   r;
    longint sa, sb, ci, sr;
    longint ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ci = c ? 64'sd1 : 64'sd0;
    if (!s) begin
      sr      = sa + sb + ci;
      r.sum   = a + b + {31'b0, c};
      r.carry = (ua + ub + ci) > 64'sd4294967295;
    end else begin
      sr      = sa - sb - ci;
      r.sum   = a - b - {31'b0, c};
      r.carry = ua >= (ub + ci);
    end
    r.ovf  = sr != longint'($signed(r.sum));
    r.zero = r.sum == 32'd0;
    r.neg  = r.sum[31];
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic res_t outs();
    return {out_sum, out_carry, out_overflow,
            out_zero, out_negative};
  endfunction

  task automatic run_op(input logic [31:0] a, b,
                        input logic c, s,
                        output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_carry  = c;
    in_sub    = s;
    out_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      #1;
    end while (!out_valid && lat < 10);
  endtask

  task automatic test_reset();
    clr = 1'b1;
    in_valid = 0; in_a = 0; in_b = 0;
    in_carry = 0; in_sub = 0; out_ready = 1;
    w4_in_valid = 0; w4_in_a = 0; w4_in_b = 0;
    w64_in_valid = 0; w64_in_a = 0; w64_in_b = 0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_low: got %b want 0",
               in_ready);
    end
    clr = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, outs()} !== {2'b10, 36'd0})
    begin
      bad++;
      $display("FAIL reset_state: got %b%b %h want 10 0",
               in_ready, out_valid, outs());
    end
  endtask

  task automatic test_add_basic();
    int lat;
    res_t exp_r;
    exp_r = {32'h8, 1'b0, 1'b0, 1'b0, 1'b0};
    run_op(32'd5, 32'd3, 1'b0, 1'b0, lat);
    total++;
    if (lat != 2) begin
      bad++;
      $display("FAIL add_latency: got %0d want 2", lat);
    end
    total++;
    if (outs() !== exp_r) begin
      bad++;
      $display("FAIL add_5_3: got %h want %h",
               outs(), exp_r);
    end
  endtask

  task automatic test_add_carry();
    int lat;
    res_t exp_r;
    exp_r = {32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, lat);
    total++;
    if (outs() !== exp_r || lat != 2) begin
      bad++;
      $display("FAIL add_carry32: got %h lat %0d want %h 2",
               outs(), lat, exp_r);
    end
    @(negedge clk);
    w4_in_valid = 1; w4_in_a = 4'hF; w4_in_b = 4'h1;
    w64_in_valid = 1; w64_in_a = '1; w64_in_b = 64'd1;
    @(negedge clk);
    w4_in_valid = 0;
    w64_in_valid = 0;
    @(negedge clk);
    #1;
    total++;
    if ({w4_out_valid, w4_out_sum, w4_out_carry,
         w4_out_overflow, w4_out_zero, w4_out_negative}
        !== {1'b1, 4'h0, 4'b1010}) begin
      bad++;
      $display("FAIL add_carry4: got %b %h %b%b%b%b",
               w4_out_valid, w4_out_sum, w4_out_carry,
               w4_out_overflow, w4_out_zero,
               w4_out_negative);
    end
    total++;
    if ({w64_out_valid, w64_out_sum, w64_out_carry,
         w64_out_overflow, w64_out_zero, w64_out_negative}
        !== {1'b1, 64'h0, 4'b1010}) begin
      bad++;
      $display("FAIL add_carry64: got %b %h %b%b%b%b",
               w64_out_valid, w64_out_sum, w64_out_carry,
               w64_out_overflow, w64_out_zero,
               w64_out_negative);
    end
  endtask

  task automatic test_sub();
    int lat;
    res_t exp_r;
    exp_r = {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, lat);
    total++;
    if (outs() !== exp_r) begin
      bad++;
      $display("FAIL sub_ovf: got %h want %h",
               outs(), exp_r);
    end
    exp_r = {32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    run_op(32'd5, 32'd5, 1'b0, 1'b1, lat);
    total++;
    if (outs() !== exp_r) begin
      bad++;
      $display("FAIL sub_zero: got %h want %h",
               outs(), exp_r);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got  = 0;
    logic [31:0] exp_s;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      in_valid  = sent < 4;
      in_a      = 32'(sent + 1);
      in_b      = 32'd1;
      in_carry  = 1'b0;
      in_sub    = 1'b0;
      out_ready = !(cyc == 2 || cyc == 3);
      #1;
      if (cyc == 2 || cyc == 3) begin
        total++;
        if ({in_ready, out_valid, out_sum}
            !== {2'b01, 32'd2}) begin
          bad++;
          $display("FAIL stall_hold: got %b%b %h want 01 2",
                   in_ready, out_valid, out_sum);
        end
      end
      if (out_valid && out_ready) begin
        exp_s = 32'(got + 2);
        total++;
        if (got >= 4 || out_sum !== exp_s) begin
          bad++;
          $display("FAIL stream_order: got %h want %h n=%0d",
                   out_sum, exp_s, got);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    total++;
    if (got != 4) begin
      bad++;
      $display("FAIL stream_count: got %0d want 4", got);
    end
  endtask

  task automatic test_clr_flush();
    int lat;
    @(negedge clk);
    out_ready = 0; in_valid = 1;
    in_a = 32'd10; in_b = 32'd1;
    in_carry = 0; in_sub = 0;
    @(negedge clk);
    in_a = 32'd20;
    @(negedge clk);
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b10) begin
      bad++;
      $display("FAIL clr_full: got %b%b want 10",
               out_valid, in_ready);
    end
    clr = 1'b1;
    in_a = 32'd99;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL clr_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    clr = 0; in_valid = 0; out_ready = 1;
    #1;
    total++;
    if ({in_ready, out_valid, outs()} !== {2'b10, 36'd0})
    begin
      bad++;
      $display("FAIL clr_state: got %b%b %h want 10 0",
               in_ready, out_valid, outs());
    end
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL clr_discard: got %b want 0", out_valid);
    end
    run_op(32'd7, 32'd8, 1'b0, 1'b0, lat);
    total++;
    if (lat != 2 || out_sum !== 32'd15) begin
      bad++;
      $display("FAIL clr_next: got %h lat %0d want f 2",
               out_sum, lat);
    end
  endtask

  task automatic test_random();
    res_t q[$];
    res_t e, hold_v;
    logic held = 1'b0;
    int n = 0;
    int cyc = 0;
    while ((n < 10000 || q.size() > 0) && cyc < 40000) begin
      @(negedge clk);
      if (n < 10000) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_a     = pick();
        in_b     = pick();
        in_carry = 1'($urandom_range(0, 1));
        in_sub   = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (held) begin
        total++;
        if ({out_valid, outs()} !== {1'b1, hold_v}) begin
          bad++;
          $display("FAIL rand_hold: got %b %h want 1 %h",
                   out_valid, outs(), hold_v);
        end
      end
      held   = out_valid && !out_ready;
      hold_v = outs();
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rand_extra: got %h want none",
                   outs());
        end else begin
          e = q.pop_front();
          if (outs() !== e) begin
            bad++;
            $display("FAIL rand_result: got %h want %h",
                     outs(), e);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_a, in_b, in_carry, in_sub));
        n++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (n < 10000 || q.size() != 0) begin
      bad++;
      $display("FAIL rand_timeout: got %0d sent %0d left",
               n, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_carry();
    test_sub();
    test_back_to_back();
    test_clr_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
